ctpuf_resp_voter: RTL and testbench
===================================

// Module: ctpuf_resp_voter
// PURPOSE
//  Evaluation sequencer that sits directly upstream of the tt_um_ctpuf pin wrapper.
//  It latches a challenge, steps the PUF cell array one response bit at a time, and
//  samples each raw bit VOTES times. Each bit is majority-voted, and the stable
//  RESP_BITS-wide response is presented to the wrapper's uo_out path with a
//  valid/ack handshake. It also flags any bit whose votes were not unanimous.
// PARAMETERS
//  RESP_BITS  8  response width; also the number of selectable PUF cells
//  VOTES      7  samples per bit; must be odd, >=3
//  SETTLE     4  cycles between the eval pulse and the sample; must be >=2 (covers the sync)
// PORTS
//  clk         in   1          system clock
//  rst_n       in   1          asynchronous active-low reset
//  ena         in   1          design enable; low freezes the sequencer
//  start       in   1          request an evaluation; sampled in IDLE only
//  challenge   in   8          challenge, latched on an accepted start
//  puf_bit     in   1          raw PUF output (asynchronous to clk)
//  puf_chal    out  8          latched challenge driven to the PUF array
//  puf_sel     out  clog2(RESP_BITS)  index of the cell being evaluated
//  puf_eval    out  1          one-cycle evaluate strobe to the PUF cell
//  resp        out  RESP_BITS  voted response
//  resp_valid  out  1          resp is valid; held until acked
//  resp_ack    in   1          consumer accepts resp
//  busy        out  1          high in every state except IDLE
//  unstable    out  1          at least one bit had non-unanimous votes
// BEHAVIOUR
//  Reset (asynchronous): state=IDLE; every output 0; vote/bit/settle counters 0;
//   sync flops 0.
//  Synchroniser: puf_bit passes through a 2-flop synchroniser. SAMPLE uses the
//   synchronised value.
//  FSM, advancing only when ena=1. With ena=0, state and all counters hold and
//   puf_eval is forced to 0.
//   IDLE   : start=1 -> latch challenge into puf_chal; clear resp, unstable, ones,
//            vote and bit; go to EVAL. Otherwise stay.
//   EVAL   : puf_eval=1 for this one cycle; go to SETTLE.
//   SETTLE : count SETTLE cycles with puf_eval=0; go to SAMPLE.
//   SAMPLE : ones += sync_bit; vote++. If vote==VOTES go to DECIDE, else go to EVAL.
//   DECIDE : resp[bit] = (ones > VOTES/2).
//            If ones is neither 0 nor VOTES, set unstable (sticky until the next start).
//            Clear ones and vote. If bit==RESP_BITS-1 go to DONE, else bit++ and go to EVAL.
//   DONE   : resp_valid=1. On resp_ack=1 -> IDLE, and resp_valid falls the next cycle.
//  puf_sel = bit at all times; it is 0 in IDLE.
//  Latency: start is accepted at cycle 0. resp_valid rises after
//   RESP_BITS*(VOTES*(SETTLE+2)+1) enabled cycles (344 at defaults), plus one cycle
//   for every ena=0 cycle.
//  resp and unstable hold their values through DONE and IDLE until the next accepted start.
//  Boundaries:
//   - start while busy (any state other than IDLE) is ignored.
//   - start and resp_ack in the same DONE cycle: the ack wins and the FSM goes to
//     IDLE; that start is not accepted.
//   - resp_ack outside DONE is ignored.
//   - ones counter width is clog2(VOTES+1); it cannot wrap.
//   - rst_n low mid-run aborts immediately: outputs go to 0 with no partial resp.
// TESTING
//  1. puf_bit=1 constant, challenge=0xA5, start pulse -> puf_chal=0xA5; resp_valid
//     at cycle 344; resp=0xFF; unstable=0.
//  2. puf_bit driven from bit puf_sel of 0x3C -> resp=0x3C; unstable=0; 8 eval strobes
//     per... no: 56 eval strobes in total, 7 per bit.
//  3. Pattern 0x00; at sel=2 drive 1 on 3 of 7 votes -> resp=0x00, unstable=1.
//     Repeat with 4 of 7 -> resp=0x04, unstable=1.
//  4. start during the run is ignored (latency unchanged). In DONE, start+ack in the
//     same cycle -> IDLE, busy=0, no new run. Plain ack -> resp_valid=0 next cycle.
//  5. ena=0 for 10 cycles mid-run -> puf_eval=0 throughout; resp_valid at cycle 354.
//  6. rst_n asserted at cycle 100 -> busy, resp_valid, resp, puf_eval, puf_chal = 0 at
//     once. A new start after release completes normally.

Source files
------------

// File: rtl/ctpuf_resp_voter.sv
// rtl/ctpuf_resp_voter.sv - challenge latch, per-bit PUF evaluation and majority vote
// Each response bit is evaluated VOTES times; the voted word is held with a valid/ack handshake.
module ctpuf_resp_voter #(
  parameter int RESP_BITS = 8,
  parameter int VOTES     = 7,
  parameter int SETTLE    = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ena,
  input  logic                         start,
  input  logic [7:0]                   challenge,
  input  logic                         puf_bit,
  output logic [7:0]                   puf_chal,
  output logic [$clog2(RESP_BITS)-1:0] puf_sel,
  output logic                         puf_eval,
  output logic [RESP_BITS-1:0]         resp,
  output logic                         resp_valid,
  input  logic                         resp_ack,
  output logic                         busy,
  output logic                         unstable
);

  localparam int SEL_W  = $clog2(RESP_BITS);
  localparam int ONES_W = $clog2(VOTES + 1);
  localparam int SET_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [ONES_W-1:0] C_VOTES    = ONES_W'(VOTES);
  localparam logic [ONES_W-1:0] C_HALF     = ONES_W'(VOTES / 2);
  localparam logic [SET_W-1:0]  C_SET_LAST = SET_W'(SETTLE - 1);
  localparam logic [SEL_W-1:0]  C_BIT_LAST = SEL_W'(RESP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_EVAL, S_SETTLE, S_SAMPLE, S_DECIDE, S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [1:0]          r_sync;
  logic [ONES_W-1:0]   r_ones;
  logic [ONES_W-1:0]   r_vote;
  logic [SET_W-1:0]    r_settle;
  logic [SEL_W-1:0]    r_bit;
  logic [7:0]          r_chal;
  logic [RESP_BITS-1:0] r_resp;
  logic                r_unstable;

  logic                w_sync_bit;
  logic [ONES_W-1:0]   w_vote_inc;
  logic                w_unanimous;

  assign w_sync_bit  = r_sync[1];
  assign w_vote_inc  = r_vote + ONES_W'(1);
  assign w_unanimous = (r_ones == '0) || (r_ones == C_VOTES);

  // puf_bit is asynchronous to clk; only the second flop is ever consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= 2'b00;
    else        r_sync <= {r_sync[0], puf_bit};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (ena) begin
      case (r_state)
        S_IDLE:   if (start) w_next = S_EVAL;
        S_EVAL:   w_next = S_SETTLE;
        S_SETTLE: if (r_settle == C_SET_LAST) w_next = S_SAMPLE;
        S_SAMPLE: w_next = (w_vote_inc == C_VOTES) ? S_DECIDE : S_EVAL;
        S_DECIDE: w_next = (r_bit == C_BIT_LAST) ? S_DONE : S_EVAL;
        S_DONE:   if (resp_ack) w_next = S_IDLE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ones     <= '0;
      r_vote     <= '0;
      r_settle   <= '0;
      r_bit      <= '0;
      r_chal     <= '0;
      r_resp     <= '0;
      r_unstable <= 1'b0;
    end else if (ena) begin
      case (r_state)
        S_IDLE: if (start) begin
          r_chal     <= challenge;
          r_resp     <= '0;
          r_unstable <= 1'b0;
          r_ones     <= '0;
          r_vote     <= '0;
          r_bit      <= '0;
          r_settle   <= '0;
        end
        S_SETTLE: r_settle <= (r_settle == C_SET_LAST) ? '0 : r_settle + SET_W'(1);
        S_SAMPLE: begin
          r_ones <= r_ones + ONES_W'(w_sync_bit);
          r_vote <= w_vote_inc;
        end
        S_DECIDE: begin
          r_resp[r_bit] <= (r_ones > C_HALF);
          if (!w_unanimous) r_unstable <= 1'b1;
          r_ones <= '0;
          r_vote <= '0;
          if (r_bit != C_BIT_LAST) r_bit <= r_bit + SEL_W'(1);
        end
        // puf_sel returns to 0 once the response has been taken
        S_DONE: if (resp_ack) r_bit <= '0;
        default: ;
      endcase
    end
  end

  assign puf_eval   = ena && (r_state == S_EVAL);
  assign resp_valid = (r_state == S_DONE);
  assign busy       = (r_state != S_IDLE);
  assign puf_sel    = r_bit;
  assign puf_chal   = r_chal;
  assign resp       = r_resp;
  assign unstable   = r_unstable;

endmodule

// File: tb/tb_ctpuf_resp_voter.sv
// tb/tb_ctpuf_resp_voter.sv - randomized vote-plan bench for ctpuf_resp_voter
module tb_ctpuf_resp_voter;

  localparam int RB  = 8;
  localparam int V   = 7;
  localparam int ST  = 4;
  localparam int LAT = RB * (V * (ST + 2) + 1);

  logic       clk = 1'b0;
  logic       rst_n, ena, start, resp_ack, puf_bit;
  logic [7:0] challenge, puf_chal, resp;
  logic [2:0] puf_sel;
  logic       puf_eval, resp_valid, busy, unstable;

  int checks = 0;
  int errors = 0;

  logic [V-1:0] plan [RB];
  int           vcount [RB];

  always #5 clk = ~clk;

  ctpuf_resp_voter #(.RESP_BITS(RB), .VOTES(V), .SETTLE(ST)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .challenge(challenge),
    .puf_bit(puf_bit), .puf_chal(puf_chal), .puf_sel(puf_sel), .puf_eval(puf_eval),
    .resp(resp), .resp_valid(resp_valid), .resp_ack(resp_ack), .busy(busy),
    .unstable(unstable)
  );

  function automatic void model(output logic [7:0] r, output logic u);
    r = '0;
    u = 1'b0;
    for (int b = 0; b < RB; b++) begin
      int n;
      n = $countones(plan[b]);
      r[b] = (n > V / 2);
      if (n != 0 && n != V) u = 1'b1;
    end
  endfunction

  function automatic logic [V-1:0] k_of_v(input int k);
    logic [V-1:0] p;
    p = '0;
    while ($countones(p) < k) p[$urandom_range(0, V - 1)] = 1'b1;
    return p;
  endfunction

  task automatic plan_word(input logic [7:0] w);
    for (int b = 0; b < RB; b++) plan[b] = w[b] ? '1 : '0;
  endtask

  task automatic plan_random();
    for (int b = 0; b < RB; b++)
      plan[b] = ($urandom_range(0, 1) != 0) ? V'($urandom) : ($urandom_range(0, 1) != 0 ? '1 : '0);
  endtask

  // drives puf_bit from the vote plan on every observed eval strobe
  task automatic run(input logic [7:0] chal, input bit spam, input int pause_at,
                     input int abort_at, output int lat, output int evals, output bit off_eval);
    int cyc;
    for (int i = 0; i < RB; i++) vcount[i] = 0;
    evals = 0;
    off_eval = 1'b0;
    @(negedge clk);
    challenge = chal;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (cyc < 3000) begin
      if (resp_valid) break;
      if (spam) begin
        start    = ($urandom_range(0, 1) != 0);
        resp_ack = ($urandom_range(0, 1) != 0);
        challenge = 8'($urandom);
      end
      ena = !(pause_at >= 0 && cyc >= pause_at && cyc < pause_at + 10);
      if (abort_at >= 0 && cyc == abort_at) begin
        rst_n = 1'b0;
        #1;
        break;
      end
      #1;
      if (!ena && puf_eval !== 1'b0) off_eval = 1'b1;
      if (puf_eval === 1'b1) begin
        evals++;
        if (vcount[puf_sel] < V) puf_bit = plan[puf_sel][vcount[puf_sel]];
        vcount[puf_sel]++;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    start    = 1'b0;
    resp_ack = 1'b0;
    ena      = 1'b1;
    lat      = cyc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; start = 1'b0; resp_ack = 1'b0; puf_bit = 1'b0; challenge = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", resp_valid); end
    checks++; if (resp !== 8'h00)      begin errors++; $display("FAIL reset_resp got %h want 00", resp); end
    checks++; if (unstable !== 1'b0)   begin errors++; $display("FAIL reset_unstable got %b want 0", unstable); end
    checks++; if (puf_eval !== 1'b0)   begin errors++; $display("FAIL reset_eval got %b want 0", puf_eval); end
    checks++; if (puf_chal !== 8'h00)  begin errors++; $display("FAIL reset_chal got %h want 00", puf_chal); end
    checks++; if (puf_sel !== 3'd0)    begin errors++; $display("FAIL reset_sel got %0d want 0", puf_sel); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic ack_done();
    @(negedge clk);
    resp_ack = 1'b1;
    @(negedge clk);
    resp_ack = 1'b0;
  endtask

  task automatic test_const_one();
    int lat, ev; bit off; logic [7:0] er; logic eu;
    plan_word(8'hFF);
    model(er, eu);
    run(8'hA5, 1'b0, -1, -1, lat, ev, off);
    checks++; if (puf_chal !== 8'hA5) begin errors++; $display("FAIL const_chal got %h want a5", puf_chal); end
    checks++; if (lat != LAT)         begin errors++; $display("FAIL const_latency got %0d want %0d", lat, LAT); end
    checks++; if (resp !== er)        begin errors++; $display("FAIL const_resp got %h want %h", resp, er); end
    checks++; if (unstable !== eu)    begin errors++; $display("FAIL const_unstable got %b want %b", unstable, eu); end
    ack_done();
  endtask

  task automatic test_pattern();
    int lat, ev; bit off; logic [7:0] er; logic eu;
    plan_word(8'h3C);
    model(er, eu);
    run(8'h5A, 1'b0, -1, -1, lat, ev, off);
    checks++; if (resp !== er)     begin errors++; $display("FAIL pattern_resp got %h want %h", resp, er); end
    checks++; if (unstable !== eu) begin errors++; $display("FAIL pattern_unstable got %b want %b", unstable, eu); end
    checks++; if (ev != RB * V)    begin errors++; $display("FAIL pattern_evals got %0d want %0d", ev, RB * V); end
    ack_done();
  endtask

  task automatic test_partial();
    int lat, ev; bit off; logic [7:0] er; logic eu;
    for (int k = 3; k <= 4; k++) begin
      plan_word(8'h00);
      plan[2] = k_of_v(k);
      model(er, eu);
      run(8'($urandom), 1'b0, -1, -1, lat, ev, off);
      checks++; if (resp !== er)     begin errors++; $display("FAIL partial%0d_resp got %h want %h", k, resp, er); end
      checks++; if (unstable !== eu) begin errors++; $display("FAIL partial%0d_unstable got %b want %b", k, unstable, eu); end
      ack_done();
    end
  endtask

  task automatic test_random();
    int lat, ev; bit off; logic [7:0] er; logic eu; logic [7:0] c;
    for (int n = 0; n < 6; n++) begin
      plan_random();
      model(er, eu);
      c = 8'($urandom);
      run(c, 1'b0, -1, -1, lat, ev, off);
      checks++; if (resp !== er)     begin errors++; $display("FAIL random%0d_resp got %h want %h", n, resp, er); end
      checks++; if (unstable !== eu) begin errors++; $display("FAIL random%0d_unstable got %b want %b", n, unstable, eu); end
      checks++; if (puf_chal !== c)  begin errors++; $display("FAIL random%0d_chal got %h want %h", n, puf_chal, c); end
      ack_done();
    end
  endtask

  task automatic test_back_to_back();
    int lat, ev; bit off; logic [7:0] er; logic eu; logic [7:0] c;
    plan_random();
    model(er, eu);
    c = 8'h96;
    run(c, 1'b1, -1, -1, lat, ev, off);
    checks++; if (lat != LAT)     begin errors++; $display("FAIL spam_latency got %0d want %0d", lat, LAT); end
    checks++; if (resp !== er)    begin errors++; $display("FAIL spam_resp got %h want %h", resp, er); end
    checks++; if (puf_chal !== c) begin errors++; $display("FAIL spam_chal got %h want %h", puf_chal, c); end
    repeat (3) @(negedge clk);
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL done_hold got %b want 1", resp_valid); end
    start = 1'b1; resp_ack = 1'b1; challenge = 8'h11;
    @(negedge clk);
    start = 1'b0; resp_ack = 1'b0;
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL startack_busy got %b want 0", busy); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL startack_valid got %b want 0", resp_valid); end
    repeat (5) @(negedge clk);
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL startack_norun got %b want 0", busy); end
    checks++; if (resp !== er)     begin errors++; $display("FAIL idle_resp_hold got %h want %h", resp, er); end
    checks++; if (puf_chal !== c)  begin errors++; $display("FAIL idle_chal_hold got %h want %h", puf_chal, c); end
    checks++; if (puf_sel !== 3'd0) begin errors++; $display("FAIL idle_sel got %0d want 0", puf_sel); end
    plan_random();
    model(er, eu);
    run(8'h3C, 1'b0, -1, -1, lat, ev, off);
    checks++; if (resp !== er) begin errors++; $display("FAIL b2b_resp got %h want %h", resp, er); end
    @(negedge clk);
    resp_ack = 1'b1;
    @(negedge clk);
    resp_ack = 1'b0;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL ack_valid got %b want 0", resp_valid); end
  endtask

  task automatic test_ena_pause();
    int lat, ev; bit off; logic [7:0] er; logic eu;
    plan_random();
    model(er, eu);
    run(8'hC3, 1'b0, 100, -1, lat, ev, off);
    checks++; if (off !== 1'b0)     begin errors++; $display("FAIL pause_eval got %b want 0", off); end
    checks++; if (lat != LAT + 10)  begin errors++; $display("FAIL pause_latency got %0d want %0d", lat, LAT + 10); end
    checks++; if (resp !== er)      begin errors++; $display("FAIL pause_resp got %h want %h", resp, er); end
    checks++; if (unstable !== eu)  begin errors++; $display("FAIL pause_unstable got %b want %b", unstable, eu); end
    ack_done();
  endtask

  task automatic test_reset_midrun();
    int lat, ev; bit off; logic [7:0] er; logic eu;
    plan_word(8'hFF);
    run(8'h77, 1'b0, -1, 100, lat, ev, off);
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b want 0", resp_valid); end
    checks++; if (resp !== 8'h00)      begin errors++; $display("FAIL abort_resp got %h want 00", resp); end
    checks++; if (puf_eval !== 1'b0)   begin errors++; $display("FAIL abort_eval got %b want 0", puf_eval); end
    checks++; if (puf_chal !== 8'h00)  begin errors++; $display("FAIL abort_chal got %h want 00", puf_chal); end
    @(negedge clk);
    rst_n = 1'b1;
    plan_word(8'hA5);
    model(er, eu);
    run(8'h42, 1'b0, -1, -1, lat, ev, off);
    checks++; if (lat != LAT)  begin errors++; $display("FAIL rerun_latency got %0d want %0d", lat, LAT); end
    checks++; if (resp !== er) begin errors++; $display("FAIL rerun_resp got %h want %h", resp, er); end
    ack_done();
  endtask

  initial begin
    test_reset();
    test_const_one();
    test_pattern();
    test_partial();
    test_random();
    test_back_to_back();
    test_ena_pause();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
